// File: rtl/usb_stream_fifo.sv
// CPU-visible byte bridge to the USB CDC streams: one RX FIFO (host to CPU) and one TX FIFO (CPU to host)
// behind a 4-register window. Loads are answered combinationally; all side effects commit on the clock edge.
module usb_stream_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sel_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       rx_irq_o,
  output logic       tx_irq_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_head, rx_tail, tx_head, tx_tail;
  logic [CW-1:0] rx_count, tx_count;
  logic          over, under;
  logic [1:0]    irq_en;

  logic bus_rd, bus_wr;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic set_under, set_over, clr_flags;
  logic [7:0] status;

  // Every decision below uses only the registered counts, so a same-cycle pop never frees room for a push.
  assign bus_rd   = sel_i & read_i;
  assign bus_wr   = sel_i & write_i;
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(DEPTH));

  assign rx_push   = out_valid_i & ~rx_full;
  assign rx_pop    = bus_rd & (addr_i == 2'd0) & ~rx_empty;
  assign tx_push   = bus_wr & (addr_i == 2'd0) & ~tx_full;
  assign tx_pop    = ~tx_empty & in_ready_i;
  assign set_under = bus_rd & (addr_i == 2'd0) & rx_empty;
  assign set_over  = bus_wr & (addr_i == 2'd0) & tx_full;
  assign clr_flags = bus_wr & (addr_i == 2'd1);

  assign status = {2'b00, under, over, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    data_o = 8'h00;
    if (bus_rd) begin
      case (addr_i)
        2'd0:    data_o = rx_empty ? 8'h00 : rx_mem[rx_head];
        2'd1:    data_o = status;
        2'd2:    data_o = {6'b000000, irq_en};
        default: data_o = 8'(rx_count);
      endcase
    end
  end

  assign in_data_o   = tx_empty ? 8'h00 : tx_mem[tx_head];
  assign in_valid_o  = ~tx_empty;
  assign out_ready_o = ~rx_full;
  assign rx_irq_o    = irq_en[0] & ~rx_empty;
  assign tx_irq_o    = irq_en[1] & tx_empty;

  // Storage is deliberately left out of reset; counts and pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_tail] <= out_data_i;
    if (tx_push) tx_mem[tx_tail] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_head  <= '0;
      rx_tail  <= '0;
      rx_count <= '0;
      tx_head  <= '0;
      tx_tail  <= '0;
      tx_count <= '0;
      over     <= 1'b0;
      under    <= 1'b0;
      irq_en   <= 2'b00;
    end else begin
      if (rx_push) rx_tail <= rx_tail + AW'(1);
      if (rx_pop)  rx_head <= rx_head + AW'(1);
      if (rx_push & ~rx_pop)      rx_count <= rx_count + CW'(1);
      else if (rx_pop & ~rx_push) rx_count <= rx_count - CW'(1);

      if (tx_push) tx_tail <= tx_tail + AW'(1);
      if (tx_pop)  tx_head <= tx_head + AW'(1);
      if (tx_push & ~tx_pop)      tx_count <= tx_count + CW'(1);
      else if (tx_pop & ~tx_push) tx_count <= tx_count - CW'(1);

      over  <= (over  & ~(clr_flags & data_i[4])) | set_over;
      under <= (under & ~(clr_flags & data_i[5])) | set_under;

      if (bus_wr && addr_i == 2'd2) irq_en <= data_i[1:0];
    end
  end

endmodule

// File: tb/tb_usb_stream_fifo.sv
// Directed bench for usb_stream_fifo: register map, stream handshakes, full/empty corner cases and pointer wrap.
module tb_usb_stream_fifo;

  localparam int DEPTH = 16;
  localparam int NBYTES = 3 * DEPTH;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       sel_i = 1'b0, read_i = 1'b0, write_i = 1'b0;
  logic [1:0] addr_i = 2'd0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       rx_irq_o, tx_irq_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;

  int total = 0;
  int bad = 0;

  logic [7:0] cap_data, cap_in_data;
  logic       cap_in_valid, cap_out_ready, cap_rx_irq, cap_tx_irq;

  usb_stream_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sel_i(sel_i), .read_i(read_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .rx_irq_o(rx_irq_o), .tx_irq_o(tx_irq_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus/stream cycle: drive after the falling edge, capture outputs, let the rising edge commit.
  task automatic applyStimulus(input logic s, input logic r, input logic w, input logic [1:0] a,
                               input logic [7:0] d, input logic ov, input logic [7:0] od,
                               input logic ir);
    @(negedge clk_i);
    sel_i = s; read_i = r; write_i = w; addr_i = a; data_i = d;
    out_valid_i = ov; out_data_i = od; in_ready_i = ir;
    #1;
    cap_data = data_o; cap_in_data = in_data_o; cap_in_valid = in_valid_o;
    cap_out_ready = out_ready_o; cap_rx_irq = rx_irq_o; cap_tx_irq = tx_irq_o;
    @(posedge clk_i);
    #1;
    sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0; out_valid_i = 1'b0; in_ready_i = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, a, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic hostPush(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, b, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int accepts;
    logic ready_at_full;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int rx_sent, rx_recv, tx_sent, tx_recv, cycles;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_out_ready", out_ready_o, 1);
    checkOutput("rst_in_valid", in_valid_o, 0);
    checkOutput("rst_in_data", in_data_o, 0);
    checkOutput("rst_irqs", {rx_irq_o, tx_irq_o}, 0);
    checkOutput("rst_data", data_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    idleCycle();
    checkOutput("idle_data", cap_data, 0);
    busRead(2'd1);
    checkOutput("idle_status", cap_data, 8'h04);
    busRead(2'd3);
    checkOutput("idle_rxcnt", cap_data, 0);

    // Two host bytes, RX interrupt, in-order reads
    hostPush(8'h41);
    hostPush(8'h42);
    busWrite(2'd2, 8'h01);
    idleCycle();
    checkOutput("rx_irq_on", cap_rx_irq, 1);
    busRead(2'd3);
    checkOutput("rxcnt_2", cap_data, 2);
    busRead(2'd0);
    checkOutput("rd_41", cap_data, 8'h41);
    busRead(2'd0);
    checkOutput("rd_42", cap_data, 8'h42);
    idleCycle();
    checkOutput("rx_irq_off", cap_rx_irq, 0);
    busRead(2'd1);
    checkOutput("status_after_rd", cap_data, 8'h04);

    // RX fill past capacity with CPU idle
    accepts = 0;
    ready_at_full = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      hostPush(8'(8'h60 + i));
      if (cap_out_ready) accepts++;
      if (i == DEPTH) ready_at_full = cap_out_ready;
    end
    checkOutput("rx_accepts", accepts, DEPTH);
    checkOutput("ready_when_full", ready_at_full, 0);
    busRead(2'd3);
    checkOutput("rxcnt_full", cap_data, DEPTH);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h99, 1'b0);
    checkOutput("full_rd_data", cap_data, 8'h60);
    checkOutput("full_rd_ready", cap_out_ready, 0);
    hostPush(8'h99);
    checkOutput("refill_ready", cap_out_ready, 1);
    busRead(2'd3);
    checkOutput("rxcnt_refull", cap_data, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      busRead(2'd0);
      checkOutput("rx_drain", cap_data, (i < DEPTH - 1) ? 8'(8'h61 + i) : 8'h99);
    end

    // TX overfill with host stalled, then drain
    for (int i = 0; i <= DEPTH; i++) busWrite(2'd0, 8'(i));
    busRead(2'd1);
    checkOutput("tx_full_status", cap_data, 8'h18);
    busWrite(2'd2, 8'h02);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("tx_valid", cap_in_valid, 1);
      checkOutput("tx_order", cap_in_data, 8'(i));
    end
    idleCycle();
    checkOutput("tx_empty_valid", cap_in_valid, 0);
    checkOutput("tx_empty_data", cap_in_data, 0);
    checkOutput("tx_irq_on", cap_tx_irq, 1);
    busWrite(2'd1, 8'h10);
    busRead(2'd1);
    checkOutput("over_cleared", cap_data, 8'h04);

    // Underflow and the single-entry push/pop corner
    busRead(2'd0);
    checkOutput("under_data", cap_data, 0);
    busRead(2'd1);
    checkOutput("under_status", cap_data, 8'h24);
    busWrite(2'd1, 8'h20);
    busRead(2'd1);
    checkOutput("under_cleared", cap_data, 8'h04);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h66, 1'b0);
    checkOutput("empty_push_rd", cap_data, 0);
    busRead(2'd0);
    checkOutput("after_empty_push", cap_data, 8'h66);
    busWrite(2'd1, 8'h20);
    hostPush(8'h77);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h55, 1'b0);
    checkOutput("cnt1_old_head", cap_data, 8'h77);
    busRead(2'd3);
    checkOutput("cnt1_rxcnt", cap_data, 1);
    busRead(2'd0);
    checkOutput("cnt1_new_head", cap_data, 8'h55);
    busRead(2'd1);
    checkOutput("cnt1_status", cap_data, 8'h04);

    // Random traffic in both directions across several pointer wraps
    rx_sent = 0; rx_recv = 0; tx_sent = 0; tx_recv = 0; cycles = 0;
    while ((rx_recv < NBYTES || tx_recv < NBYTES) && cycles < 3000) begin
      logic ov, rd, wr, ir;
      logic [7:0] rxb, txb;
      int rx_pre, tx_pre;
      rx_pre = rx_q.size();
      tx_pre = tx_q.size();
      ov = (rx_sent < NBYTES) && ($urandom_range(0, 2) != 0);
      rd = (rx_pre > 0) && ($urandom_range(0, 1) != 0);
      wr = (tx_sent < NBYTES) && (tx_pre < DEPTH) && ($urandom_range(0, 2) != 0);
      ir = ($urandom_range(0, 1) != 0);
      rxb = 8'(rx_sent * 7 + 3);
      txb = 8'(tx_sent * 5 + 1);
      applyStimulus(rd | wr, rd, wr, 2'd0, txb, ov, rxb, ir);
      if (rd) begin
        checkOutput("wrap_rx_order", cap_data, rx_q.pop_front());
        rx_recv++;
      end
      if (ov && rx_pre < DEPTH) begin
        rx_q.push_back(rxb);
        rx_sent++;
      end
      if (ir && tx_pre > 0) begin
        checkOutput("wrap_tx_order", cap_in_data, tx_q.pop_front());
        tx_recv++;
      end
      if (wr) begin
        tx_q.push_back(txb);
        tx_sent++;
      end
      cycles++;
    end
    checkOutput("wrap_done", (rx_recv == NBYTES && tx_recv == NBYTES), 1);
    busRead(2'd3);
    checkOutput("wrap_rxcnt", cap_data, 0);
    checkOutput("wrap_in_valid", cap_in_valid, 0);

    // Reset while both FIFOs hold data
    hostPush(8'hA1);
    busWrite(2'd0, 8'hB2);
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    checkOutput("midrst_in_valid", in_valid_o, 0);
    checkOutput("midrst_out_ready", out_ready_o, 1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    busRead(2'd3);
    checkOutput("midrst_rxcnt", cap_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
